// File: rtl/sram_like_responder_pkg.sv
// Shared encodings for the SRAM-like responder.
// Request bundle, FSM states and delay counter width.
package sram_like_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef struct packed {
    logic        wr;
    size_e       size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic [3:0] eff_we(input req_t r);
    return r.wr ? r.wstrb : 4'b0000;
  endfunction

endpackage

// File: rtl/sram_like_responder_fifo.sv
// Request FIFO: power-of-two ring buffer with occupancy count.
// Push is refused when full, pop when empty.
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only pointer/count state is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like request/response front end over a one-cycle backing RAM.
// Requests queue in a FIFO and are serviced in order, one at a time.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 16,
  parameter int RESP_DELAY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [CNT_W-1:0] DLY_M1 =
    CNT_W'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

  req_t             entry;
  req_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             st_idle;
  logic             st_wait;
  logic             st_access;
  logic             st_resp;
  logic             unused_head;

  assign entry = '{
    wr:    wr,
    size:  size_e'(size),
    wstrb: wstrb,
    addr:  addr,
    wdata: wdata
  };

  // addr_ok comes from registered occupancy only, so a same-cycle
  // pop never opens a slot for a push.
  assign addr_ok = !full;
  assign push    = req && addr_ok;
  assign pop     = st_resp;

  sram_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign st_idle   = (state == ST_IDLE);
  assign st_wait   = (state == ST_WAIT);
  assign st_access = (state == ST_ACCESS);
  assign st_resp   = (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (1'b1)
      st_idle: begin
        if (!empty) begin
          if (RESP_DELAY > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = DLY_M1;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      st_wait: begin
        if (cnt == '0) state_nxt = ST_ACCESS;
        else           cnt_nxt   = cnt - 1'b1;
      end
      st_access: state_nxt = ST_RESP;
      st_resp:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign ram_en    = st_access;
  assign ram_we    = st_access ? eff_we(head) : 4'b0000;
  assign ram_addr  = head.addr[ADDR_W+1:2];
  assign ram_wdata = head.wdata;

  assign data_ok = st_resp;
  assign rdata   = (st_resp && !head.wr) ? ram_rdata : 32'h0;

  // Size and the byte-offset/upper address bits ride along unused.
  assign unused_head = ^{head.size, head.addr};

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized bench for sram_like_responder against a queue-based model.
// A second instance with RESP_DELAY=5 covers the delayed paths.
module tb_sram_like_responder;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int D0    = 0;
  localparam int D5    = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic load  = 1'b1;

  logic        req   = 1'b0;
  logic        req5  = 1'b0;
  logic        wr    = 1'b0;
  logic [1:0]  size  = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic          addr_ok, data_ok, ram_en;
  logic [31:0]   rdata, ram_wdata, ram_rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;

  logic          addr_ok5, data_ok5, ram_en5;
  logic [31:0]   rdata5, ram_wdata5, ram_rdata5;
  logic [3:0]    ram_we5;
  logic [AW-1:0] ram_addr5;

  always #5 clk = ~clk;

  sram_like_responder #(
    .DEPTH(DEPTH), .ADDR_W(AW), .RESP_DELAY(D0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  sram_like_responder #(
    .DEPTH(DEPTH), .ADDR_W(AW), .RESP_DELAY(D5)
  ) dut5 (
    .clk(clk), .reset(reset), .req(req5), .wr(wr), .size(size),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok5),
    .data_ok(data_ok5), .rdata(rdata5), .ram_en(ram_en5),
    .ram_we(ram_we5), .ram_addr(ram_addr5), .ram_wdata(ram_wdata5),
    .ram_rdata(ram_rdata5)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  // Backing RAM for the main instance; junk on idle cycles.
  logic [31:0] env_mem [64];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_val(i);
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) env_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= ram_en ? env_mem[ram_addr] : $urandom;
  end

  always @(posedge clk)
    ram_rdata5 <= ram_en5 ? (32'hC0DE0000 | 32'(ram_addr5)) : 32'h0;

  typedef struct {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] adr;
    logic [31:0] wd;
    int          done;
    logic [31:0] exp;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ref_mem [64];
  int          last_done = -1000;
  int          cyc = 0;
  bit          live = 1'b0;
  int          checks = 0;
  int          fails = 0;

  int            last_ok_cyc = -1;
  logic [31:0]   last_ok_dat = 32'h0;
  int            last_acc_cyc = -1;
  logic [3:0]    last_we = 4'h0;
  logic [AW-1:0] last_ram_addr = '0;
  logic [31:0]   last_ram_wd = 32'h0;

  int          ok5_cyc[$];
  logic [31:0] ok5_dat[$];
  int          acc5 = 0;
  bit          aok5_log[int];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit   aok_e, acc, rsp;
    int   idx;
    ent_t e;
    aok_e = (q.size() < DEPTH);
    acc = (q.size() > 0) && (q[0].done - 1 == cyc);
    rsp = (q.size() > 0) && (q[0].done == cyc);
    if (live) begin
      chk("addr_ok", 32'(addr_ok), 32'(aok_e));
      chk("ram_en", 32'(ram_en), 32'(acc));
      if (acc) begin
        idx = int'(q[0].adr[AW+1:2]);
        chk("ram_addr", 32'(ram_addr), 32'(idx));
        chk("ram_we", 32'(ram_we), 32'(q[0].wr ? q[0].strb : 4'h0));
        chk("ram_wdata", ram_wdata, q[0].wd);
        if (q[0].wr) begin
          for (int b = 0; b < 4; b++)
            if (q[0].strb[b]) ref_mem[idx][8*b +: 8] = q[0].wd[8*b +: 8];
        end else begin
          q[0].exp = ref_mem[idx];
        end
        last_acc_cyc  = cyc;
        last_we       = ram_we;
        last_ram_addr = ram_addr;
        last_ram_wd   = ram_wdata;
      end else begin
        chk("ram_we_idle", 32'(ram_we), 32'h0);
      end
      chk("data_ok", 32'(data_ok), 32'(rsp));
      if (rsp) begin
        chk("rdata", rdata, q[0].wr ? 32'h0 : q[0].exp);
        void'(q.pop_front());
      end else begin
        chk("rdata_idle", rdata, 32'h0);
      end
      if (data_ok) begin
        last_ok_cyc = cyc;
        last_ok_dat = rdata;
      end
      if (data_ok5) begin
        ok5_cyc.push_back(cyc);
        ok5_dat.push_back(rdata5);
      end
      aok5_log[cyc] = addr_ok5;
      if (req5 && addr_ok5 && !reset) acc5++;
    end
    if (reset) begin
      q.delete();
      last_done = -1000;
      live = 1'b1;
    end else if (req && aok_e) begin
      e.wr   = wr;
      e.strb = wstrb;
      e.adr  = addr;
      e.wd   = wdata;
      e.exp  = 32'h0;
      e.done = cyc + 3 + D0;
      if (last_done + 3 + D0 > e.done) e.done = last_done + 3 + D0;
      last_done = e.done;
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_op();
    wr    = 1'($urandom);
    wstrb = 4'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    size  = 2'($urandom_range(0, 2));
  endtask

  task automatic clr5();
    ok5_cyc.delete();
    ok5_dat.delete();
    acc5 = 0;
  endtask

  int t;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    cycle();
    load = 1'b0;
    cycle();
    reset = 1'b0;
    chk("rst_addr_ok5", 32'(addr_ok5), 32'h1);
    chk("rst_data_ok5", 32'(data_ok5), 32'h0);
    chk("rst_ram_en5", 32'(ram_en5), 32'h0);

    // Single read with known RAM word.
    req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = 4'h0;
    t = cyc;
    cycle();
    req = 1'b0;
    repeat (6) cycle();
    chk("rd_acc_lat", 32'(last_acc_cyc - t), 32'd2);
    chk("rd_ram_addr", 32'(last_ram_addr), 32'd4);
    chk("rd_lat", 32'(last_ok_cyc - t), 32'd3);
    chk("rd_rdata", last_ok_dat, 32'hDEADBEEF);

    // Partial-strobe write.
    req = 1'b1; wr = 1'b1; addr = 32'h8; wdata = 32'h11223344;
    wstrb = 4'b0011;
    t = cyc;
    cycle();
    req = 1'b0;
    repeat (6) cycle();
    chk("wr_we", 32'(last_we), 32'h3);
    chk("wr_ram_addr", 32'(last_ram_addr), 32'd2);
    chk("wr_ram_wdata", last_ram_wd, 32'h11223344);
    chk("wr_lat", 32'(last_ok_cyc - t), 32'd3);
    chk("wr_rdata", last_ok_dat, 32'h0);

    // Write with no strobes still completes.
    req = 1'b1; wr = 1'b1; addr = 32'hC; wdata = 32'hCAFEF00D;
    wstrb = 4'b0000;
    t = cyc;
    cycle();
    req = 1'b0;
    repeat (6) cycle();
    chk("wz_acc", 32'(last_acc_cyc - t), 32'd2);
    chk("wz_we", 32'(last_we), 32'h0);
    chk("wz_lat", 32'(last_ok_cyc - t), 32'd3);

    // Delayed instance: req held 6 cycles fills the FIFO.
    clr5();
    t = cyc;
    wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req5 = 1'b1;
      addr = 32'h40 + 32'(i * 4);
      cycle();
    end
    req5 = 1'b0;
    repeat (40) cycle();
    chk("fill_acc", 32'(acc5), 32'd4);
    chk("fill_n", 32'(ok5_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ok5_cyc.size()) begin
        chk("fill_dat", ok5_dat[k], 32'hC0DE0000 | 32'(16 + k));
        chk("fill_cyc", 32'(ok5_cyc[k] - t), 32'(8 * (k + 1)));
      end
    end
    chk("fill_aok_lo", 32'(aok5_log[t + 4]), 32'h0);
    chk("fill_aok_pop", 32'(aok5_log[t + 8]), 32'h0);
    chk("fill_aok_back", 32'(aok5_log[t + 9]), 32'h1);

    // Single delayed read.
    clr5();
    req5 = 1'b1; addr = 32'h1C;
    t = cyc;
    cycle();
    req5 = 1'b0;
    repeat (12) cycle();
    chk("d5_n", 32'(ok5_cyc.size()), 32'd1);
    chk("d5_lat", 32'(ok5_cyc.size() > 0 ? ok5_cyc[0] - t : -1), 32'd8);
    chk("d5_dat", ok5_dat.size() > 0 ? ok5_dat[0] : 32'hX, 32'hC0DE0007);

    // Reset while waiting with two entries queued.
    clr5();
    req5 = 1'b1; addr = 32'h20;
    cycle();
    addr = 32'h24;
    cycle();
    req5 = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clr5();
    repeat (20) cycle();
    chk("rw_no_ok", 32'(ok5_cyc.size()), 32'd0);
    chk("rw_aok", 32'(addr_ok5), 32'h1);
    req5 = 1'b1; addr = 32'h28;
    t = cyc;
    cycle();
    req5 = 1'b0;
    repeat (12) cycle();
    chk("rw_lat", 32'(ok5_cyc.size() > 0 ? ok5_cyc[0] - t : -1), 32'd8);
    chk("rw_dat", ok5_dat.size() > 0 ? ok5_dat[0] : 32'hX, 32'hC0DE000A);

    // Back-to-back mixed traffic wrapping the pointers.
    for (int i = 0; i < 10; i++) begin
      req = 1'b1;
      rand_op();
      cycle();
    end
    req = 1'b0;
    repeat (40) cycle();
    chk("b2b_drain", 32'(q.size()), 32'd0);

    // Random traffic with a reset pulse mid-stream.
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 2) != 0);
      rand_op();
      reset = (i == 200);
      cycle();
    end
    req = 1'b0;
    reset = 1'b0;
    repeat (40) cycle();
    chk("rnd_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
